// File: rtl/fibonacci_checker.sv
// Streaming Fibonacci checker: seeds from the first two terms, then verifies that each
// later beat continues the sequence (one or two terms per beat), with a sticky fail flag.
module fibonacci_checker #(
  parameter int W      = 16,
  parameter bit DOUBLE = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         restart,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_num,
  input  logic [W-1:0] in_num2,
  output logic         match,
  output logic         mismatch,
  output logic         fail,
  output logic [15:0]  term_cnt,
  output logic [W-1:0] expected
);

  typedef enum logic [1:0] {
    SEED0 = 2'd0,
    SEED1 = 2'd1,
    CHECK = 2'd2,
    FAIL  = 2'd3
  } state_t;

  localparam logic [15:0] CNT_INC = DOUBLE ? 16'd2 : 16'd1;

  state_t       state_r, state_s;
  logic [W-1:0] a_r, b_r, a_s, b_s;
  logic [15:0]  cnt_r, cnt_s;
  logic         match_r, mismatch_r, fail_r;
  logic         match_s, mismatch_s, fail_s;
  logic         rdy_r;
  logic         accept_s, ok_s;
  logic [W-1:0] e0_s, e1_s;

  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [15:0] inc);
    logic [16:0] s;
    s = {1'b0, c} + {1'b0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign e0_s     = a_r + b_r;
  assign e1_s     = b_r + e0_s;
  // rdy_r keeps in_ready low until the first edge after reset release
  assign in_ready = rdy_r && !restart && (state_r != FAIL);
  assign accept_s = in_valid && in_ready;

  assign match    = match_r;
  assign mismatch = mismatch_r;
  assign fail     = fail_r;
  assign term_cnt = cnt_r;
  assign expected = (state_r == CHECK) ? e0_s : {W{1'b0}};

  // Next-state, data-path and pulse computation
  always_comb begin
    state_s    = state_r;
    a_s        = a_r;
    b_s        = b_r;
    cnt_s      = cnt_r;
    fail_s     = fail_r;
    match_s    = 1'b0;
    mismatch_s = 1'b0;
    ok_s       = 1'b0;
    if (restart) begin
      state_s = SEED0;
      a_s     = {W{1'b0}};
      b_s     = {W{1'b0}};
      cnt_s   = 16'd0;
      fail_s  = 1'b0;
    end else if (accept_s) begin
      case (state_r)
        SEED0: begin
          cnt_s = sat_add(cnt_r, CNT_INC);
          if (DOUBLE) begin
            a_s     = in_num;
            b_s     = in_num2;
            state_s = CHECK;
          end else begin
            b_s     = in_num;
            state_s = SEED1;
          end
        end
        SEED1: begin
          a_s     = b_r;
          b_s     = in_num;
          cnt_s   = sat_add(cnt_r, CNT_INC);
          state_s = CHECK;
        end
        CHECK: begin
          if (DOUBLE) begin
            ok_s = (in_num == e0_s) && (in_num2 == e1_s);
          end else begin
            ok_s = (in_num == e0_s);
          end
          if (ok_s) begin
            match_s = 1'b1;
            cnt_s   = sat_add(cnt_r, CNT_INC);
            if (DOUBLE) begin
              a_s = in_num;
              b_s = in_num2;
            end else begin
              a_s = b_r;
              b_s = in_num;
            end
          end else begin
            mismatch_s = 1'b1;
            fail_s     = 1'b1;
            state_s    = FAIL;
          end
        end
        default: begin
          state_s = state_r;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= SEED0;
      a_r        <= {W{1'b0}};
      b_r        <= {W{1'b0}};
      cnt_r      <= 16'd0;
      match_r    <= 1'b0;
      mismatch_r <= 1'b0;
      fail_r     <= 1'b0;
      rdy_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      a_r        <= a_s;
      b_r        <= b_s;
      cnt_r      <= cnt_s;
      match_r    <= match_s;
      mismatch_r <= mismatch_s;
      fail_r     <= fail_s;
      rdy_r      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fibonacci_checker.sv
// Table-driven bench for fibonacci_checker: one instance per beat width, plus
// hand-written reset sequences.
module tb_fibonacci_checker;

  logic        clk = 1'b0;
  logic        rst_n, restart;
  logic        valid0, valid1;
  logic [15:0] num, num2;
  logic        rdy0, m0, mm0, f0, rdy1, m1, mm1, f1;
  logic [15:0] c0, e0, c1, e1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        sel;
    logic        rs;
    logic        vld;
    logic [15:0] n;
    logic [15:0] n2;
    logic        m;
    logic        mm;
    logic        f;
    logic        rdy;
    logic [15:0] cnt;
    logic [15:0] ex;
  } row_t;

  row_t tbl[$];
  row_t tbl2[$];

  fibonacci_checker #(.W(16), .DOUBLE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .restart(restart), .in_valid(valid0), .in_ready(rdy0),
    .in_num(num), .in_num2(num2), .match(m0), .mismatch(mm0), .fail(f0),
    .term_cnt(c0), .expected(e0)
  );

  fibonacci_checker #(.W(16), .DOUBLE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .restart(restart), .in_valid(valid1), .in_ready(rdy1),
    .in_num(num), .in_num2(num2), .match(m1), .mismatch(mm1), .fail(f1),
    .term_cnt(c1), .expected(e1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s[%0d] got %0d want %0d", nm, idx, got, want);
    end
  endtask

  task automatic apply_row(input row_t r, input int idx);
    restart = r.rs;
    num     = r.n;
    num2    = r.n2;
    valid0  = r.vld && !r.sel;
    valid1  = r.vld && r.sel;
    @(posedge clk);
    @(negedge clk);
    if (r.sel) begin
      chk("match", idx, {31'd0, m1}, {31'd0, r.m});
      chk("mismatch", idx, {31'd0, mm1}, {31'd0, r.mm});
      chk("fail", idx, {31'd0, f1}, {31'd0, r.f});
      chk("in_ready", idx, {31'd0, rdy1}, {31'd0, r.rdy});
      chk("term_cnt", idx, {16'd0, c1}, {16'd0, r.cnt});
      chk("expected", idx, {16'd0, e1}, {16'd0, r.ex});
    end else begin
      chk("match", idx, {31'd0, m0}, {31'd0, r.m});
      chk("mismatch", idx, {31'd0, mm0}, {31'd0, r.mm});
      chk("fail", idx, {31'd0, f0}, {31'd0, r.f});
      chk("in_ready", idx, {31'd0, rdy0}, {31'd0, r.rdy});
      chk("term_cnt", idx, {16'd0, c0}, {16'd0, r.cnt});
      chk("expected", idx, {16'd0, e0}, {16'd0, r.ex});
    end
  endtask

  initial begin
    // sel rs vld n n2 | m mm f rdy cnt expected
    tbl.push_back('{1'b1, 1'b0, 1'b1, 16'd1,  16'd1,  1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 16'd2});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 16'd2,  16'd3,  1'b1, 1'b0, 1'b0, 1'b1, 16'd4, 16'd5});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 16'd5,  16'd8,  1'b1, 1'b0, 1'b0, 1'b1, 16'd6, 16'd13});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 16'd13, 16'd22, 1'b0, 1'b1, 1'b1, 1'b0, 16'd6, 16'd0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 16'd1,  16'd0,  1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 16'd0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 16'd1,  16'd0,  1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 16'd2});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 16'd2,  16'd0,  1'b1, 1'b0, 1'b0, 1'b1, 16'd3, 16'd3});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 16'd3,  16'd0,  1'b1, 1'b0, 1'b0, 1'b1, 16'd4, 16'd5});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 16'd5,  16'd0,  1'b1, 1'b0, 1'b0, 1'b1, 16'd5, 16'd8});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 16'd8,  16'd0,  1'b1, 1'b0, 1'b0, 1'b1, 16'd6, 16'd13});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 16'd0,  16'd0,  1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 16'd1,  16'd0,  1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 16'd0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 16'd1,  16'd0,  1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 16'd2});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 16'd2,  16'd0,  1'b1, 1'b0, 1'b0, 1'b1, 16'd3, 16'd3});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 16'd4,  16'd0,  1'b0, 1'b1, 1'b1, 1'b0, 16'd3, 16'd0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 16'd7,  16'd0,  1'b0, 1'b0, 1'b1, 1'b0, 16'd3, 16'd0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 16'd5,  16'd0,  1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 16'd0,  16'd0,  1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 16'd28657, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 16'd0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 16'd46368, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 16'd9489});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 16'd9489,  16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd3, 16'd55857});
    // after the mid-CHECK reset
    tbl2.push_back('{1'b0, 1'b0, 1'b1, 16'd1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 16'd0});
    tbl2.push_back('{1'b0, 1'b0, 1'b1, 16'd1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 16'd2});
    tbl2.push_back('{1'b0, 1'b0, 1'b1, 16'd2, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd3, 16'd3});

    rst_n   = 1'b0;
    restart = 1'b0;
    valid0  = 1'b0;
    valid1  = 1'b0;
    num     = 16'd0;
    num2    = 16'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready0", 0, {31'd0, rdy0}, 32'd0);
    chk("rst_ready1", 0, {31'd0, rdy1}, 32'd0);
    chk("rst_cnt0", 0, {16'd0, c0}, 32'd0);
    chk("rst_fail0", 0, {31'd0, f0}, 32'd0);
    chk("rst_expected1", 0, {16'd0, e1}, 32'd0);

    rst_n = 1'b1;
    #1;
    chk("rel_ready0", 0, {31'd0, rdy0}, 32'd0);
    @(negedge clk);
    chk("rel_ready0", 1, {31'd0, rdy0}, 32'd1);
    chk("rel_ready1", 1, {31'd0, rdy1}, 32'd1);

    for (int i = 0; i < tbl.size(); i++) begin
      apply_row(tbl[i], i);
    end
    valid0  = 1'b0;
    valid1  = 1'b0;
    restart = 1'b0;

    // dut0 is in CHECK with a match pulse showing; reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_match", 0, {31'd0, m0}, 32'd0);
    chk("async_mismatch", 0, {31'd0, mm0}, 32'd0);
    chk("async_fail", 0, {31'd0, f0}, 32'd0);
    chk("async_ready", 0, {31'd0, rdy0}, 32'd0);
    chk("async_cnt", 0, {16'd0, c0}, 32'd0);
    chk("async_expected", 0, {16'd0, e0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel2_ready", 0, {31'd0, rdy0}, 32'd0);
    @(negedge clk);
    chk("rel2_ready", 1, {31'd0, rdy0}, 32'd1);
    for (int i = 0; i < tbl2.size(); i++) begin
      apply_row(tbl2[i], 100 + i);
    end
    valid0 = 1'b0;
    @(negedge clk);
    chk("pulse_one_cycle", 0, {31'd0, m0}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
